// File: rtl/uart_tx_frame_arbiter_if.sv
// Handshake bundle between the frame arbiter, its byte-stream requesters and
// the downstream uart_tx byte transmitter.
//   req_valid/req_data/req_last/req_ready : per-requester byte streams (packed, 8 bits per requester)
//   tx_data/tx_valid/tx_ready             : byte handshake towards uart_tx
// master: the arbiter side.  slave: requesters plus uart_tx (the environment).
interface uart_tx_frame_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one uart_tx byte transmitter between N_REQ byte-stream requesters.
// Each frame goes to one round-robin winner and is sent as
// SOF, ID (ID_BASE + index), up to MAX_LEN payload bytes, XOR checksum (ID ^ payload).
// Longer messages are cut at MAX_LEN and the rest goes out in a later frame.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : handshake bundle (master modport): requester streams and uart_tx byte port
//   busy       : high whenever the FSM is not idle
//   grant_id   : index of the current / most recent granted requester
//   frame_done : one-cycle pulse in the cycle the checksum byte is transferred
//
// state     | meaning
// S_IDLE    | no frame; pick the next requester round-robin from rr_ptr
// S_SOF     | send start-of-frame byte
// S_ID      | send ID byte, seeds the checksum
// S_PAYLOAD | pass requester bytes straight through to uart_tx
// S_CSUM    | send checksum, then advance rr_ptr past the granted requester
module uart_tx_frame_arbiter #(
  parameter int         N_REQ    = 4,
  parameter int         MAX_LEN  = 8,
  parameter logic [7:0] SOF_BYTE = 8'hA5,
  parameter logic [7:0] ID_BASE  = 8'h10,
  localparam int        IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  uart_tx_frame_arbiter_if.master   bus,
  output logic                      busy,
  output logic [IDW-1:0]            grant_id,
  output logic                      frame_done
);

  localparam int             CW       = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0]  LEN_LAST = CW'(MAX_LEN - 1);
  localparam logic [IDW-1:0] IDX_LAST = IDW'(N_REQ - 1);

  typedef enum logic [2:0] {S_IDLE, S_SOF, S_ID, S_PAYLOAD, S_CSUM} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] winner;
  logic [7:0]     csum;
  logic [CW-1:0]  count;
  logic [7:0]     id_byte;
  logic [7:0]     pay_byte;
  logic           pay_xfer;

  assign id_byte  = ID_BASE + {{(8-IDW){1'b0}}, grant_id};
  assign pay_byte = bus.req_data[grant_id*8 +: 8];
  assign pay_xfer = (state == S_PAYLOAD) && bus.req_valid[grant_id] && bus.tx_ready;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && bus.req_valid[idx]) begin
        winner = IDW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.req_ready = '0;
    case (state)
      S_IDLE: begin
        if (|bus.req_valid) state_nxt = S_SOF;
      end
      S_SOF: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = SOF_BYTE;
        if (bus.tx_ready) state_nxt = S_ID;
      end
      S_ID: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = id_byte;
        if (bus.tx_ready) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        // Pure pass-through: a requester gap simply drops tx_valid.
        bus.tx_valid            = bus.req_valid[grant_id];
        bus.tx_data             = pay_byte;
        bus.req_ready[grant_id] = bus.tx_ready;
        if (pay_xfer && (bus.req_last[grant_id] || count == LEN_LAST)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum;
        if (bus.tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant_id <= '0;
      csum     <= 8'h00;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            grant_id <= winner;
            csum     <= 8'h00;
            count    <= '0;
          end
        end
        S_ID: begin
          if (bus.tx_ready) csum <= id_byte;
        end
        S_PAYLOAD: begin
          if (pay_xfer) begin
            csum  <= csum ^ pay_byte;
            count <= count + 1'b1;
          end
        end
        S_CSUM: begin
          if (bus.tx_ready) rr_ptr <= (grant_id == IDX_LAST) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_CSUM) && bus.tx_ready;

endmodule
